// File: rtl/wb_arbiter.sv
// wb_arbiter: shares one register-file write port between core writeback and a queued
// long-latency result stream. Define WB_BYPASS_EN to write B results straight to the RF when the queue is empty.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CORE_WR,
  input  logic [4:0]               CORE_RD,
  input  logic [31:0]              CORE_DIN,
  output logic                     CORE_READY,
  input  logic                     B_VALID,
  input  logic [4:0]               B_RD,
  input  logic [31:0]              B_DIN,
  output logic                     B_READY,
  input  logic [4:0]               RS1,
  input  logic [4:0]               RS2,
  output logic                     HAZ1,
  output logic                     HAZ2,
  output logic                     RF_WR,
  output logic [4:0]               RF_RD,
  output logic [31:0]              RF_DIN,
  output logic [$clog2(DEPTH):0]   PEND_CNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    G_NONE,
    G_FORCE,
    G_CORE,
    G_DRAIN,
    G_BYPASS
  } grant_e;

  logic [4:0]       rd_mem_q   [DEPTH];
  logic [4:0]       rd_mem_d   [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];
  logic [31:0]      data_mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    wait_q, wait_d;

  grant_e grant;
  logic   empty, full, core_req;
  logic   waw_hit, rs1_hit, rs2_hit;
  logic   push, pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign core_req = CORE_WR && (CORE_RD != 5'd0);

  // Every valid slot is compared, so an entry being popped this cycle still reports.
  always_comb begin
    waw_hit = 1'b0;
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (rd_mem_q[i] == CORE_RD)) waw_hit = 1'b1;
      if (valid_q[i] && (rd_mem_q[i] == RS1))     rs1_hit = 1'b1;
      if (valid_q[i] && (rd_mem_q[i] == RS2))     rs2_hit = 1'b1;
    end
  end

  assign HAZ1 = rs1_hit && (RS1 != 5'd0);
  assign HAZ2 = rs2_hit && (RS2 != 5'd0);

  always_comb begin
    grant = G_NONE;
    if (!RST) begin
      if (!empty && ((wait_q == WAIT_MAX) || (core_req && waw_hit))) begin
        grant = G_FORCE;
      end else if (core_req) begin
        grant = G_CORE;
      end else if (!empty) begin
        grant = G_DRAIN;
`ifdef WB_BYPASS_EN
      end else if (B_VALID && (B_RD != 5'd0)) begin
        grant = G_BYPASS;
`endif
      end
    end
  end

  always_comb begin
    RF_WR      = 1'b0;
    RF_RD      = 5'd0;
    RF_DIN     = 32'd0;
    CORE_READY = !RST && (grant != G_FORCE);
    B_READY    = !RST && !full;
    unique case (grant)
      G_FORCE, G_DRAIN: begin
        RF_WR  = 1'b1;
        RF_RD  = rd_mem_q[rd_ptr_q];
        RF_DIN = data_mem_q[rd_ptr_q];
      end
      G_CORE: begin
        RF_WR  = 1'b1;
        RF_RD  = CORE_RD;
        RF_DIN = CORE_DIN;
      end
      G_BYPASS: begin
        RF_WR  = 1'b1;
        RF_RD  = B_RD;
        RF_DIN = B_DIN;
      end
      default: begin
        RF_WR = 1'b0;
      end
    endcase
  end

  // Register-0 results complete the handshake but never occupy a slot.
  assign pop  = (grant == G_FORCE) || (grant == G_DRAIN);
  assign push = B_VALID && B_READY && (B_RD != 5'd0) && (grant != G_BYPASS);

  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    valid_d    = valid_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      rd_mem_d[wr_ptr_q]   = B_RD;
      data_mem_d[wr_ptr_q] = B_DIN;
      valid_d[wr_ptr_q]    = 1'b1;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (pop || empty) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + WW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
    end
  end

  // Payload storage carries no reset; the valid bits qualify it.
  always_ff @(posedge CLK) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign PEND_CNT = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of the arbitration rules.
module tb_wb_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int K_NONE  = 0;
  localparam int K_FORCE = 1;
  localparam int K_CORE  = 2;
  localparam int K_DRAIN = 3;
  localparam int K_BYP   = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CORE_WR;
  logic [4:0]  CORE_RD;
  logic [31:0] CORE_DIN;
  logic        CORE_READY;
  logic        B_VALID;
  logic [4:0]  B_RD;
  logic [31:0] B_DIN;
  logic        B_READY;
  logic [4:0]  RS1, RS2;
  logic        HAZ1, HAZ2;
  logic        RF_WR;
  logic [4:0]  RF_RD;
  logic [31:0] RF_DIN;
  logic [$clog2(DEPTH):0] PEND_CNT;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: pending results in drain order as {rd, data}, plus the starvation counter.
  logic [36:0] exp_q[$];
  int          wait_m = 0;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .CORE_WR(CORE_WR), .CORE_RD(CORE_RD), .CORE_DIN(CORE_DIN), .CORE_READY(CORE_READY),
    .B_VALID(B_VALID), .B_RD(B_RD), .B_DIN(B_DIN), .B_READY(B_READY),
    .RS1(RS1), .RS2(RS2), .HAZ1(HAZ1), .HAZ2(HAZ2),
    .RF_WR(RF_WR), .RF_RD(RF_RD), .RF_DIN(RF_DIN), .PEND_CNT(PEND_CNT)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    CORE_WR  = 1'b0;
    CORE_RD  = 5'd0;
    CORE_DIN = 32'd0;
    B_VALID  = 1'b0;
    B_RD     = 5'd0;
    B_DIN    = 32'd0;
    RS1      = 5'd0;
    RS2      = 5'd0;
  endtask

  task automatic drive_core(input logic [4:0] rd, input logic [31:0] din);
    CORE_WR  = 1'b1;
    CORE_RD  = rd;
    CORE_DIN = din;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] rd, input logic [31:0] din);
    B_VALID = v;
    B_RD    = rd;
    B_DIN   = din;
  endtask

  // Scoreboard: derive this cycle's outputs from the pending queue, compare, then advance the model.
  always @(negedge CLK) begin : model_cmp
    int          kind;
    logic        waw, h1, h2, bready_e, core_ready_e, push, pop, was_empty;
    logic [36:0] head;
    logic [4:0]  exp_rd;
    logic [31:0] exp_din;
    if (chk_en) begin
      waw = 1'b0;
      h1  = 1'b0;
      h2  = 1'b0;
      foreach (exp_q[i]) begin
        if (CORE_WR && CORE_RD != 5'd0 && exp_q[i][36:32] == CORE_RD) waw = 1'b1;
        if (RS1 != 5'd0 && exp_q[i][36:32] == RS1) h1 = 1'b1;
        if (RS2 != 5'd0 && exp_q[i][36:32] == RS2) h2 = 1'b1;
      end
      head     = (exp_q.size() > 0) ? exp_q[0] : 37'd0;
      bready_e = !RST && (exp_q.size() < DEPTH);
      kind     = K_NONE;
      if (!RST) begin
        if (exp_q.size() > 0 && (wait_m == STARVE_LIMIT || waw)) kind = K_FORCE;
        else if (CORE_WR && CORE_RD != 5'd0)                     kind = K_CORE;
        else if (exp_q.size() > 0)                               kind = K_DRAIN;
        else if (BYPASS && B_VALID && B_RD != 5'd0)              kind = K_BYP;
      end
      core_ready_e = !RST && (kind != K_FORCE);
      case (kind)
        K_FORCE, K_DRAIN: begin exp_rd = head[36:32]; exp_din = head[31:0]; end
        K_CORE:           begin exp_rd = CORE_RD;     exp_din = CORE_DIN;   end
        K_BYP:            begin exp_rd = B_RD;        exp_din = B_DIN;      end
        default:          begin exp_rd = 5'd0;        exp_din = 32'd0;      end
      endcase

      chk("core_ready", {31'd0, CORE_READY}, {31'd0, core_ready_e});
      chk("b_ready",    {31'd0, B_READY},    {31'd0, bready_e});
      chk("rf_wr",      {31'd0, RF_WR},      {31'd0, (kind != K_NONE)});
      if (kind != K_NONE) begin
        chk("rf_rd",  {27'd0, RF_RD}, {27'd0, exp_rd});
        chk("rf_din", RF_DIN, exp_din);
      end
      chk("haz1",     {31'd0, HAZ1}, {31'd0, h1});
      chk("haz2",     {31'd0, HAZ2}, {31'd0, h2});
      chk("pend_cnt", 32'(PEND_CNT), 32'(exp_q.size()));

      if (RST) begin
        exp_q.delete();
        wait_m = 0;
      end else begin
        pop       = (kind == K_FORCE) || (kind == K_DRAIN);
        push      = B_VALID && bready_e && (B_RD != 5'd0) && (kind != K_BYP);
        was_empty = (exp_q.size() == 0);
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back({B_RD, B_DIN});
        if (pop || was_empty)           wait_m = 0;
        else if (wait_m < STARVE_LIMIT) wait_m = wait_m + 1;
      end
    end
  end

  initial begin : stim
    int   n_wait;
    bit   found;
    logic hold;
    logic [4:0]  seen_rd;
    logic [31:0] seen_din;

    RST = 1'b1;
    drive_idle();
    @(posedge CLK);
    chk_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // First cycle out of reset: core write goes straight through.
    drive_core(5'd5, 32'hA5A5A5A5);
    RS1 = 5'd5;
    #1;
    chk("rst_b_ready",    {31'd0, B_READY},    32'd1);
    chk("rst_core_ready", {31'd0, CORE_READY}, 32'd1);
    chk("rst_pend",       32'(PEND_CNT),       32'd0);
    chk("rst_haz1",       {31'd0, HAZ1},       32'd0);
    chk("core0_rf_wr",    {31'd0, RF_WR},      32'd1);
    chk("core0_rf_rd",    {27'd0, RF_RD},      32'd5);
    chk("core0_rf_din",   RF_DIN,              32'hA5A5A5A5);

    // Starvation: busy core plus one queued result.
    step();
    drive_core(5'd1, 32'h11111111);
    drive_b(1'b1, 5'd7, 32'h77);
    RS1 = 5'd0;
    #1;
    chk("starve_push_rd", {27'd0, RF_RD}, 32'd1);
    step();
    drive_b(1'b0, 5'd0, 32'd0);
    n_wait = 0;
    found  = 1'b0;
    seen_rd  = 5'd0;
    seen_din = 32'd0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (!CORE_READY) begin
        found    = 1'b1;
        seen_rd  = RF_RD;
        seen_din = RF_DIN;
      end else begin
        n_wait++;
        step();
      end
    end
    chk("starve_found",  {31'd0, found}, 32'd1);
    chk("starve_cycles", n_wait, STARVE_LIMIT);
    chk("starve_rd",     {27'd0, seen_rd}, 32'd7);
    chk("starve_din",    seen_din, 32'h77);
    step();
    #1;
    chk("starve_after_ready", {31'd0, CORE_READY}, 32'd1);
    chk("starve_after_pend",  32'(PEND_CNT), 32'd0);

    // Write-after-write guard.
    step();
    drive_b(1'b1, 5'd3, 32'h33);
    step();
    drive_b(1'b0, 5'd0, 32'd0);
    drive_core(5'd3, 32'hC3C3C3C3);
    #1;
    chk("waw1_ready", {31'd0, CORE_READY}, 32'd0);
    chk("waw1_rd",    {27'd0, RF_RD}, 32'd3);
    chk("waw1_din",   RF_DIN, 32'h33);
    step();
    #1;
    chk("waw2_ready", {31'd0, CORE_READY}, 32'd1);
    chk("waw2_rd",    {27'd0, RF_RD}, 32'd3);
    chk("waw2_din",   RF_DIN, 32'hC3C3C3C3);

    // Fill the queue behind a busy core.
    drive_core(5'd1, 32'h22222222);
    for (int k = 0; k < DEPTH; k++) begin
      step();
      drive_b(1'b1, 5'(10 + k), 32'(32'h100 + k));
      #1;
      chk("fill_b_ready", {31'd0, B_READY}, 32'd1);
    end
    step();
    drive_b(1'b1, 5'd14, 32'hBAD);
    RS1 = 5'd12;
    RS2 = 5'd20;
    #1;
    chk("full_b_ready", {31'd0, B_READY}, 32'd0);
    chk("full_pend",    32'(PEND_CNT), 32'd4);
    chk("full_haz1",    {31'd0, HAZ1}, 32'd1);
    chk("full_haz2",    {31'd0, HAZ2}, 32'd0);
    RS1 = 5'd0;
    RS2 = 5'd10;
    #1;
    chk("full_haz1_r0", {31'd0, HAZ1}, 32'd0);
    chk("full_haz2_hd", {31'd0, HAZ2}, 32'd1);
    step();
    CORE_WR = 1'b0;
    drive_b(1'b0, 5'd0, 32'd0);
    #1;
    for (int k = 0; k < 12 && PEND_CNT != 0; k++) step();
    chk("drain_empty", 32'(PEND_CNT), 32'd0);

    // Register-0 result is accepted and dropped.
    step();
    drive_b(1'b1, 5'd0, 32'hDEAD);
    #1;
    chk("r0_b_ready", {31'd0, B_READY}, 32'd1);
    chk("r0_rf_wr",   {31'd0, RF_WR}, 32'd0);
    step();
    drive_b(1'b0, 5'd0, 32'd0);
    #1;
    chk("r0_pend", 32'(PEND_CNT), 32'd0);

    // Reset discards queued results.
    drive_core(5'd1, 32'h44444444);
    for (int k = 0; k < 3; k++) begin
      step();
      drive_b(1'b1, 5'(21 + k), 32'(k));
    end
    step();
    drive_b(1'b0, 5'd0, 32'd0);
    #1;
    chk("prerst_pend", 32'(PEND_CNT), 32'd3);
    RST = 1'b1;
    step();
    RST = 1'b0;
    RS1 = 5'd21;
    RS2 = 5'd23;
    #1;
    chk("postrst_pend", 32'(PEND_CNT), 32'd0);
    chk("postrst_haz1", {31'd0, HAZ1}, 32'd0);
    chk("postrst_haz2", {31'd0, HAZ2}, 32'd0);

    // Idle port, empty queue, single result.
    step();
    CORE_WR = 1'b0;
    drive_b(1'b1, 5'd9, 32'h99);
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_rf_wr",  {31'd0, RF_WR}, 32'd1);
    chk("byp_rf_rd",  {27'd0, RF_RD}, 32'd9);
    chk("byp_rf_din", RF_DIN, 32'h99);
    step();
    drive_b(1'b0, 5'd0, 32'd0);
    #1;
    chk("byp_pend", 32'(PEND_CNT), 32'd0);
`else
    chk("q9_rf_wr0", {31'd0, RF_WR}, 32'd0);
    step();
    drive_b(1'b0, 5'd0, 32'd0);
    #1;
    chk("q9_pend",   32'(PEND_CNT), 32'd1);
    chk("q9_rf_wr1", {31'd0, RF_WR}, 32'd1);
    chk("q9_rf_rd",  {27'd0, RF_RD}, 32'd9);
    chk("q9_rf_din", RF_DIN, 32'h99);
`endif

    // Random traffic; a refused core request is held until accepted.
    hold = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      step();
      RST = ($urandom_range(0, 399) == 0);
      if (!hold) begin
        CORE_WR  = ($urandom_range(0, 9) < 7);
        CORE_RD  = 5'($urandom_range(0, 7));
        CORE_DIN = $urandom;
      end
      B_VALID = ($urandom_range(0, 99) < 45);
      B_RD    = 5'($urandom_range(0, 7));
      B_DIN   = $urandom;
      RS1     = 5'($urandom_range(0, 7));
      RS2     = 5'($urandom_range(0, 7));
      #1;
      hold = CORE_WR && !CORE_READY && !RST;
    end

    step();
    RST = 1'b0;
    drive_idle();
    repeat (DEPTH + 4) step();
    chk("final_pend", 32'(PEND_CNT), 32'd0);

    @(posedge CLK);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the single register-file write port (RF_WR/RF_RD/RF_DIN) between the core writeback path and a long-latency result source (multiply/divide or load unit). Long-latency results are queued in a DEPTH-entry in-order FIFO and drained into idle write slots. A starvation limit forces a drain, and a write-after-write guard also forces one. The block also reports read hazards against pending entries so the pipeline can stall.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 8: waiting cycles with a non-empty FIFO before a forced drain; at least 1.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- CORE_WR  in  1  core writeback request.
- CORE_RD  in  5  core destination register.
- CORE_DIN  in  32  core write data.
- CORE_READY  out  1  core write accepted this cycle; low means the core stalls and holds its request.
- B_VALID  in  1  long-latency result valid.
- B_RD  in  5  long-latency destination register.
- B_DIN  in  32  long-latency result data.
- B_READY  out  1  FIFO can accept; handshake completes when B_VALID && B_READY.
- RS1, RS2  in  5 each  hazard query addresses.
- HAZ1, HAZ2  out  1 each  a valid FIFO entry targets RS1/RS2; never set for register 0.
- RF_WR  out  1  write enable to the register file.
- RF_RD  out  5  write address to the register file.
- RF_DIN  out  32  write data to the register file.
- PEND_CNT  out  clog2(DEPTH)+1  number of valid FIFO entries.

## Operation
- State:
  - FIFO of {rd, data}, with read pointer, write pointer and count.
  - WAIT_CNT counter, width clog2(STARVE_LIMIT)+1.
- Grant decision each cycle with RST low, first match wins:
  1. Forced drain. The FIFO is non-empty and either WAIT_CNT==STARVE_LIMIT, or CORE_WR is set with CORE_RD!=0 and CORE_RD equal to any valid entry's rd. Action: RF write of the FIFO head, pop, CORE_READY=0.
  2. Core. CORE_WR is set and CORE_RD!=0. Action: RF write {CORE_RD, CORE_DIN}, CORE_READY=1.
  3. Idle drain. The FIFO is non-empty. Action: RF write of the FIFO head, pop, CORE_READY=1.
  4. No write. RF_WR=0 and CORE_READY=1.
- Core requests with CORE_RD==0 are accepted (CORE_READY=1) with no RF write.
- Push:
  - Occurs when B_VALID && B_READY && B_RD!=0.
  - A handshake with B_RD==0 is accepted and discarded.
  - B_READY = !full. A full FIFO blocks the push even in a cycle that pops.
  - A push and a pop in the same cycle are legal when not full; the count is unchanged.
- WAIT_CNT:
  - Cleared on any pop, or when the FIFO is empty.
  - Otherwise incremented, saturating at STARVE_LIMIT.
- Hazards:
  - HAZ1/HAZ2 are combinational compares of RS1/RS2 against all valid entries.
  - The entry popped this cycle still counts as pending.
  - An entry pushed this cycle does not count until the next cycle.
- Ordering: FIFO entries drain strictly in order, so the WAW guard keeps a newer core write from being overwritten by an older queued result.

## Timing
- RF_WR, RF_RD, RF_DIN, CORE_READY, HAZ1 and HAZ2 are combinational from state and inputs.
- The register file captures the write on the same rising edge as the grant.
- Core writeback latency is 0 cycles.
- Queued result latency is at least 1 cycle from push to RF write; worst case is DEPTH×(STARVE_LIMIT+1) cycles.
- While RST is high:
  - RF_WR=0, CORE_READY=0, B_READY=0.
  - On the clock edge, the FIFO is emptied, pointers and WAIT_CNT are set to 0, and queued results are discarded.
- First cycle after reset: B_READY=1, CORE_READY=1, HAZ1=HAZ2=0, PEND_CNT=0.
- PEND_CNT is registered and updates on the edge after a push or pop.

## Configuration
- WB_BYPASS_EN defined:
  - Condition: FIFO empty, B_VALID=1, B_RD!=0, and no core write is granted (CORE_WR=0 or CORE_RD=0).
  - Action: the B result is written directly to the RF in the same cycle (RF_RD=B_RD, RF_DIN=B_DIN) and is not pushed. HAZ is not raised for it.
- Not defined: every B result passes through the FIFO, with a minimum latency of 1 cycle.

## Test plan
- Reset, then CORE_WR=1, CORE_RD=5, CORE_DIN=0xA5A5A5A5 -> same cycle RF_WR=1, RF_RD=5, RF_DIN=0xA5A5A5A5, CORE_READY=1; B_READY=1, PEND_CNT=0.
- Core requests continuously to r1, plus one B push {r7, 0x77}; STARVE_LIMIT=8 -> after 8 waiting cycles, one cycle with CORE_READY=0 and RF write {7, 0x77}; then CORE_READY=1.
- Push {r3, 0x33}, then core write to r3 -> cycle 1: RF writes {3, 0x33} with CORE_READY=0; cycle 2: RF writes core data to r3.
- Push DEPTH=4 entries with the core continuously busy -> B_READY=0 after the 4th; PEND_CNT=4; HAZ1=1 for RS1 equal to any queued rd, and 0 for RS1=0.
- B push with B_RD=0 -> accepted, PEND_CNT unchanged, no RF write. RST asserted with 3 entries queued -> PEND_CNT=0 and HAZ1=HAZ2=0 the next cycle.
- Core idle, FIFO empty, B push {r9, 0x99} -> with WB_BYPASS_EN: RF write in the same cycle, PEND_CNT stays 0. Without it: PEND_CNT=1, and the RF write follows one cycle later.
